// File: rtl/bcd_digit_feeder.sv
// Sequential 16-bit binary to 4-digit BCD converter (double dabble, one bit per clock)
// feeding the seven-segment multiplexer. Optional macro: BCD_OVERFLOW_ERR_EN ("Errr" on overflow).
module bcd_digit_feeder #(
    parameter logic [3:0] DP_MASK = 4'b1111
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] value,
    output logic        busy,
    output logic        done,
    output logic [3:0]  hex3,
    output logic [3:0]  hex2,
    output logic [3:0]  hex1,
    output logic [3:0]  hex0,
    output logic [3:0]  dp_out,
    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SHIFT  = 2'd1,
        COMMIT = 2'd2
    } state_t;

`ifdef BCD_OVERFLOW_ERR_EN
    localparam logic [15:0] OVF_CODE = 16'hEAAA;
`else
    localparam logic [15:0] OVF_CODE = 16'h9999;
`endif

    state_t      r_state;
    logic [15:0] r_bin;
    logic [19:0] r_bcd;
    logic [3:0]  r_cnt;
    logic        r_ovf;
    logic        r_busy;
    logic        r_done;
    logic [15:0] r_hex;
    logic [19:0] w_bcd_adj;

    // Add-3 correction on every BCD nibble before the shift.
    always_comb begin
        w_bcd_adj = r_bcd;
        for (int i = 0; i < 5; i++) begin
            if (r_bcd[i*4 +: 4] >= 4'd5)
                w_bcd_adj[i*4 +: 4] = r_bcd[i*4 +: 4] + 4'd3;
        end
    end

    // start is sampled only in IDLE; done is a single-cycle pulse in the cycle the
    // new digits first appear, and busy is already low in that cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_bin   <= 16'h0000;
            r_bcd   <= 20'h00000;
            r_cnt   <= 4'd0;
            r_ovf   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_hex   <= 16'h0000;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_bin   <= value;
                        r_bcd   <= 20'h00000;
                        r_ovf   <= (value > 16'd9999);
                        r_cnt   <= 4'd15;
                        r_busy  <= 1'b1;
                        r_state <= SHIFT;
                    end
                end
                SHIFT: begin
                    {r_bcd, r_bin} <= {w_bcd_adj[18:0], r_bin, 1'b0};
                    if (r_cnt == 4'd0)
                        r_state <= COMMIT;
                    else
                        r_cnt <= r_cnt - 4'd1;
                end
                COMMIT: begin
                    r_hex   <= r_ovf ? OVF_CODE : r_bcd[15:0];
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign busy      = r_busy;
    assign done      = r_done;
    assign hex3      = r_hex[15:12];
    assign hex2      = r_hex[11:8];
    assign hex1      = r_hex[7:4];
    assign hex0      = r_hex[3:0];
    assign dp_out    = DP_MASK;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_bcd_digit_feeder.sv
// Directed plus randomized bench for bcd_digit_feeder with a decimal-arithmetic reference model.
// Build with the same BCD_OVERFLOW_ERR_EN setting as the design.
module tb_bcd_digit_feeder;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] value;
    logic        busy;
    logic        done;
    logic [3:0]  hex3, hex2, hex1, hex0;
    logic [3:0]  dp_out;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    bcd_digit_feeder dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .value     (value),
        .busy      (busy),
        .done      (done),
        .hex3      (hex3),
        .hex2      (hex2),
        .hex1      (hex1),
        .hex0      (hex0),
        .dp_out    (dp_out),
        .dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    // Expected display word, from decimal arithmetic on the input value.
    function automatic logic [15:0] model(input int v);
        logic [15:0] r;
        if (v > 9999) begin
`ifdef BCD_OVERFLOW_ERR_EN
            r = {4'hE, 4'hA, 4'hA, 4'hA};
`else
            r = {4'd9, 4'd9, 4'd9, 4'd9};
`endif
        end else begin
            r[15:12] = 4'((v / 1000) % 10);
            r[11:8]  = 4'((v / 100) % 10);
            r[7:4]   = 4'((v / 10) % 10);
            r[3:0]   = 4'(v % 10);
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Called one cycle into a conversion (cyc0 cycles already elapsed); waits for done.
    task automatic wait_done(input int cyc0, input logic [15:0] exp_hex);
        int cyc;
        cyc = cyc0;
        while (done !== 1'b1 && cyc < 40) begin
            chk("busy_during", {31'b0, busy}, 1);
            tick();
            cyc++;
        end
        chk("latency", cyc, 17);
        chk("done_pulse", {31'b0, done}, 1);
        chk("busy_at_done", {31'b0, busy}, 0);
        chk("digits", {16'b0, hex3, hex2, hex1, hex0}, {16'b0, exp_hex});
    endtask

    // Issues a start from IDLE (or from the done cycle) and waits for its done.
    task automatic convert(input logic [15:0] v);
        start = 1'b1;
        value = v;
        tick();
        start = 1'b0;
        value = 16'($urandom);
        wait_done(0, model(int'(v)));
    endtask

    task automatic after_done();
        tick();
        chk("done_low", {31'b0, done}, 0);
        chk("busy_low", {31'b0, busy}, 0);
    endtask

    // Digits may change only in a done cycle or after a reset edge; dp_out is constant.
    logic [15:0] prev_hex;
    logic        prev_reset;
    bit          mon_init = 0;
    always @(negedge clk) begin
        chk("dp_out", {28'b0, dp_out}, 32'hF);
        if (mon_init && !done && !prev_reset)
            chk("hex_stable", {16'b0, hex3, hex2, hex1, hex0}, {16'b0, prev_hex});
        prev_hex   = {hex3, hex2, hex1, hex0};
        prev_reset = reset;
        mon_init   = 1;
    end

    initial begin
        int seen;
        logic [15:0] v;
        reset = 1'b1;
        start = 1'b0;
        value = 16'd0;
        tick();
        start = 1'b1;
        value = 16'd1234;
        tick();
        reset = 1'b0;
        start = 1'b0;
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_done", {31'b0, done}, 0);
        chk("rst_hex", {16'b0, hex3, hex2, hex1, hex0}, 0);
        chk("rst_state_idle", {30'b0, dbg_state}, 0);
        tick();

        convert(16'd1234);
        after_done();

        convert(16'd0);
        convert(16'd9999);
        after_done();

        convert(16'd10000);
        after_done();
        convert(16'd65535);
        after_done();

        // A start during a conversion is ignored and not queued.
        convert(16'd1);
        after_done();
        start = 1'b1;
        value = 16'd42;
        tick();
        start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("busy_pre_ignore", {31'b0, busy}, 1);
            tick();
        end
        start = 1'b1;
        value = 16'd777;
        tick();
        start = 1'b0;
        wait_done(5, model(42));
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            tick();
            if (done === 1'b1) seen++;
        end
        chk("no_queued_done", seen, 0);
        chk("digits_hold", {16'b0, hex3, hex2, hex1, hex0}, {16'b0, model(42)});

        // Reset in the middle of a conversion aborts it.
        convert(16'd5678);
        after_done();
        start = 1'b1;
        value = 16'd321;
        tick();
        start = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 0);
        chk("abort_hex", {16'b0, hex3, hex2, hex1, hex0}, 0);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (done === 1'b1) seen++;
            tick();
        end
        chk("abort_no_done", seen, 0);
        convert(16'd321);
        after_done();

        // Random values, biased so both in-range and overflow cases occur.
        for (int n = 0; n < 24; n++) begin
            if (n % 3 == 0) v = 16'($urandom);
            else            v = 16'($urandom_range(0, 10500));
            convert(v);
            if ($urandom_range(0, 1) == 1) after_done();
        end
        after_done();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        bad++;
        $display("FAIL global_timeout observed=running expected=finished");
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "timeout");
    end

endmodule
